// File: rtl/sdram_init_aref_ctrl.sv
// SDRAM power-up initialisation and periodic auto-refresh controller.
// It runs the power-up wait, PRECHARGE ALL, the init auto-refreshes and the
// mode register load, then raises refresh requests on a free-running interval.
// Each request is executed once the command arbiter grants it.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_WAIT   | power-up wait, counting down T_POWERUP
// S_PRE    | PRECHARGE ALL goes on the bus at the next edge
// S_TRP    | precharge recovery before the first init AREF
// S_AREF   | init AUTO REFRESH goes on the bus at the next edge
// S_TRFC   | refresh recovery between init AREFs / before MRS
// S_MRS    | LOAD MODE REGISTER goes on the bus at the next edge
// S_TMRD   | mode register recovery, leaves into S_IDLE with INIT_DONE
// S_IDLE   | initialised, waiting for a grant while a refresh is pending
// S_RPRE   | grant accepted, PRECHARGE ALL goes on the bus at the next edge
// S_RTRP   | precharge recovery before the runtime AREF
// S_RAREF  | runtime AUTO REFRESH goes on the bus at the next edge
// S_RTRFC  | refresh recovery, leaves into S_IDLE with AREF_DONE
//
// Every output is registered; each command state lasts one cycle, so its
// command is driven for exactly that one cycle after it.

module sdram_init_aref_ctrl #(
    parameter int         SDRAM_ADDR_WIDTH   = 12,
    parameter int         SDRAM_BANK_WIDTH   = 2,
    parameter int         T_POWERUP          = 20000,
    parameter int         T_RP               = 2,
    parameter int         T_RFC              = 7,
    parameter int         T_MRD              = 2,
    parameter int         INIT_AREF_NUM      = 8,
    parameter int         REF_INTERVAL       = 780,
    parameter int         CAS_LATENCY        = 3,
    parameter logic [2:0] BURST_CODE         = 3'b111,
    parameter bit         WRITE_BURST_SINGLE = 1'b0
) (
    input  logic                        Sys_clk,
    input  logic                        Rst_n,
    input  logic                        AREF_EN,
    output logic                        AREF_REQ,
    output logic                        AREF_DONE,
    output logic                        BUSY,
    output logic                        INIT_DONE,
    output logic                        REF_ERR,
    output logic [3:0]                  COMMAND,
    output logic [SDRAM_ADDR_WIDTH-1:0] A_ADDR,
    output logic [SDRAM_BANK_WIDTH-1:0] BANK_ADDR
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TMR_MAX = max2(max2(T_POWERUP, T_RP), max2(T_RFC, T_MRD));
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int RW      = $clog2(REF_INTERVAL + 1);
    localparam int CW      = $clog2(INIT_AREF_NUM + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    localparam logic [2:0]                  CL_BITS   = 3'(CAS_LATENCY);
    localparam logic [9:0]                  MODE_LOW  = {WRITE_BURST_SINGLE, 2'b00, CL_BITS, 1'b0, BURST_CODE};
    localparam logic [SDRAM_ADDR_WIDTH-1:0] MODE_WORD = SDRAM_ADDR_WIDTH'(MODE_LOW);
    // A10 high selects all banks for PRECHARGE
    localparam logic [SDRAM_ADDR_WIDTH-1:0] PRE_WORD  = SDRAM_ADDR_WIDTH'(1024);

    typedef enum logic [3:0] {
        S_WAIT, S_PRE, S_TRP, S_AREF, S_TRFC, S_MRS, S_TMRD,
        S_IDLE, S_RPRE, S_RTRP, S_RAREF, S_RTRFC
    } state_t;

    state_t                      state, state_nxt;
    logic [TW-1:0]               tmr, tmr_nxt;
    logic [CW-1:0]               aref_cnt, aref_cnt_nxt;
    logic [RW-1:0]               ref_tmr;
    logic [1:0]                  pending, pending_nxt;
    logic                        tc, grant;
    logic [3:0]                  cmd_nxt;
    logic [SDRAM_ADDR_WIDTH-1:0] addr_nxt;
    logic                        busy_nxt, done_nxt, init_done_nxt;

    assign tc    = INIT_DONE && (ref_tmr == '0);
    assign grant = (state == S_IDLE) && (pending != 2'd0) && AREF_EN;

    // State register, sequencing timer and init refresh count
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_WAIT;
            tmr      <= TW'(T_POWERUP - 1);
            aref_cnt <= '0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            aref_cnt <= aref_cnt_nxt;
        end
    end

    // Next state and next registered outputs. A wait of T cycles between two
    // commands needs T-1 cycles outside the command states, so a wait of one
    // cycle jumps straight to the next command state.
    always_comb begin
        state_nxt    = state;
        tmr_nxt      = tmr;
        aref_cnt_nxt = aref_cnt;
        cmd_nxt      = CMD_NOP;
        addr_nxt     = '0;

        unique case (state)
            S_WAIT: begin
                if (tmr == '0) state_nxt = S_PRE;
                else           tmr_nxt   = tmr - TW'(1);
            end
            S_PRE: begin
                cmd_nxt  = CMD_PRE;
                addr_nxt = PRE_WORD;
                if (T_RP == 1) begin
                    state_nxt = S_AREF;
                end else begin
                    state_nxt = S_TRP;
                    tmr_nxt   = TW'(T_RP - 2);
                end
            end
            S_TRP: begin
                if (tmr == '0) state_nxt = S_AREF;
                else           tmr_nxt   = tmr - TW'(1);
            end
            S_AREF: begin
                cmd_nxt      = CMD_AREF;
                aref_cnt_nxt = aref_cnt + CW'(1);
                if (T_RFC == 1) begin
                    state_nxt = (aref_cnt == CW'(INIT_AREF_NUM - 1)) ? S_MRS : S_AREF;
                end else begin
                    state_nxt = S_TRFC;
                    tmr_nxt   = TW'(T_RFC - 2);
                end
            end
            S_TRFC: begin
                if (tmr == '0) state_nxt = (aref_cnt == CW'(INIT_AREF_NUM)) ? S_MRS : S_AREF;
                else           tmr_nxt   = tmr - TW'(1);
            end
            S_MRS: begin
                cmd_nxt   = CMD_MRS;
                addr_nxt  = MODE_WORD;
                state_nxt = S_TMRD;
                tmr_nxt   = TW'(T_MRD - 1);
            end
            S_TMRD: begin
                if (tmr == '0) state_nxt = S_IDLE;
                else           tmr_nxt   = tmr - TW'(1);
            end
            S_IDLE: begin
                if (grant) state_nxt = S_RPRE;
            end
            S_RPRE: begin
                cmd_nxt  = CMD_PRE;
                addr_nxt = PRE_WORD;
                if (T_RP == 1) begin
                    state_nxt = S_RAREF;
                end else begin
                    state_nxt = S_RTRP;
                    tmr_nxt   = TW'(T_RP - 2);
                end
            end
            S_RTRP: begin
                if (tmr == '0) state_nxt = S_RAREF;
                else           tmr_nxt   = tmr - TW'(1);
            end
            S_RAREF: begin
                cmd_nxt   = CMD_AREF;
                state_nxt = S_RTRFC;
                tmr_nxt   = TW'(T_RFC - 1);
            end
            S_RTRFC: begin
                if (tmr == '0) state_nxt = S_IDLE;
                else           tmr_nxt   = tmr - TW'(1);
            end
            default: begin
                state_nxt = S_WAIT;
                tmr_nxt   = TW'(T_POWERUP - 1);
            end
        endcase

        // BUSY stays low in the grant cycle and drops together with the
        // return to S_IDLE
        busy_nxt      = !((state == S_IDLE) || (state_nxt == S_IDLE));
        done_nxt      = (state == S_RTRFC) && (state_nxt == S_IDLE);
        init_done_nxt = INIT_DONE || (state_nxt == S_IDLE);
    end

    // Saturating count of refreshes owed; a grant and a terminal count in
    // the same cycle cancel
    always_comb begin
        pending_nxt = pending;
        if (tc && !grant && (pending != 2'd3)) pending_nxt = pending + 2'd1;
        else if (grant && !tc)                 pending_nxt = pending - 2'd1;
    end

    // Refresh interval down-counter, held loaded until init completes
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n)              ref_tmr <= RW'(REF_INTERVAL - 1);
        else if (!INIT_DONE)     ref_tmr <= RW'(REF_INTERVAL - 1);
        else if (ref_tmr == '0)  ref_tmr <= RW'(REF_INTERVAL - 1);
        else                     ref_tmr <= ref_tmr - RW'(1);
    end

    // Pending count, request and sticky overrun flag
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pending  <= 2'd0;
            AREF_REQ <= 1'b0;
            REF_ERR  <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            AREF_REQ <= (pending_nxt != 2'd0);
            REF_ERR  <= REF_ERR || (tc && (pending == 2'd3));
        end
    end

    // Registered command bus and status outputs
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            COMMAND   <= CMD_NOP;
            A_ADDR    <= '0;
            BANK_ADDR <= '0;
            BUSY      <= 1'b1;
            INIT_DONE <= 1'b0;
            AREF_DONE <= 1'b0;
        end else begin
            COMMAND   <= cmd_nxt;
            A_ADDR    <= addr_nxt;
            BANK_ADDR <= '0;
            BUSY      <= busy_nxt;
            INIT_DONE <= init_done_nxt;
            AREF_DONE <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_init_aref_ctrl.sv
// Bench for sdram_init_aref_ctrl with small timing parameters. The reference
// model predicts every output for every edge from the command timeline
// arithmetic; a monitor compares the DUT against each prediction.

module tb_sdram_init_aref_ctrl;

    localparam int         AW    = 12;
    localparam int         BW    = 2;
    localparam int         TPU   = 10;
    localparam int         TRP   = 2;
    localparam int         TRFC  = 7;
    localparam int         TMRD  = 2;
    localparam int         NAREF = 2;
    localparam int         RI    = 20;
    localparam int         CL    = 3;
    localparam logic [2:0] BURST = 3'b111;
    localparam int         WBS   = 0;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] MRS  = 4'b0000;

    localparam int          MRS_T  = TPU + TRP + NAREF * TRFC;
    localparam int          DONE_T = MRS_T + TMRD;
    localparam int          MODE_I = (WBS << 9) | (CL << 4) | int'(BURST);
    localparam logic [AW-1:0] PRE_A  = AW'(1 << 10);
    localparam logic [AW-1:0] MODE_A = AW'(MODE_I);

    logic          Sys_clk = 1'b0;
    logic          Rst_n   = 1'b0;
    logic          AREF_EN = 1'b0;
    logic          AREF_REQ, AREF_DONE, BUSY, INIT_DONE, REF_ERR;
    logic [3:0]    COMMAND;
    logic [AW-1:0] A_ADDR;
    logic [BW-1:0] BANK_ADDR;

    sdram_init_aref_ctrl #(
        .SDRAM_ADDR_WIDTH   (AW),
        .SDRAM_BANK_WIDTH   (BW),
        .T_POWERUP          (TPU),
        .T_RP               (TRP),
        .T_RFC              (TRFC),
        .T_MRD              (TMRD),
        .INIT_AREF_NUM      (NAREF),
        .REF_INTERVAL       (RI),
        .CAS_LATENCY        (CL),
        .BURST_CODE         (BURST),
        .WRITE_BURST_SINGLE (WBS[0])
    ) dut (
        .Sys_clk   (Sys_clk),
        .Rst_n     (Rst_n),
        .AREF_EN   (AREF_EN),
        .AREF_REQ  (AREF_REQ),
        .AREF_DONE (AREF_DONE),
        .BUSY      (BUSY),
        .INIT_DONE (INIT_DONE),
        .REF_ERR   (REF_ERR),
        .COMMAND   (COMMAND),
        .A_ADDR    (A_ADDR),
        .BANK_ADDR (BANK_ADDR)
    );

    always #5 Sys_clk = ~Sys_clk;

    typedef struct {
        int            t;
        logic [3:0]    cmd;
        logic [AW-1:0] addr;
        logic [BW-1:0] bank;
        logic          req;
        logic          done;
        logic          busy;
        logic          idone;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: edge index since reset release, refreshes owed,
    // overrun flag and the edge of the most recent accepted grant
    int   t_mdl = 0;
    int   pend  = 0;
    bit   err_m = 1'b0;
    int   gs    = -1;

    function automatic exp_t reset_exp();
        exp_t e;
        e.t = -1; e.cmd = NOP; e.addr = '0; e.bank = '0;
        e.req = 1'b0; e.done = 1'b0; e.busy = 1'b1; e.idone = 1'b0; e.err = 1'b0;
        return e;
    endfunction

    function automatic exp_t model_step(input bit en);
        exp_t e;
        bit   tc, allowed, grant;
        int   t;
        t       = t_mdl;
        tc      = (t > DONE_T) && (((t - DONE_T) % RI) == 0);
        allowed = (t > DONE_T) && ((gs < 0) || (t >= gs + 2 + TRP + TRFC));
        grant   = allowed && (pend > 0) && en;
        if (tc && pend == 3) err_m = 1'b1;
        pend = pend + int'(tc) - int'(grant);
        if (pend > 3) pend = 3;
        if (grant) gs = t;

        e.t = t; e.cmd = NOP; e.addr = '0; e.bank = '0;
        if (t == TPU || (gs >= 0 && t == gs + 1)) begin
            e.cmd  = PRE;
            e.addr = PRE_A;
        end
        for (int k = 0; k < NAREF; k++)
            if (t == TPU + TRP + k * TRFC) e.cmd = AREF;
        if (gs >= 0 && t == gs + 1 + TRP) e.cmd = AREF;
        if (t == MRS_T) begin
            e.cmd  = MRS;
            e.addr = MODE_A;
        end
        e.done  = (gs >= 0) && (t == gs + 1 + TRP + TRFC);
        e.busy  = (t < DONE_T) || ((gs >= 0) && (t >= gs + 1) && (t <= gs + TRP + TRFC));
        e.idone = (t >= DONE_T);
        e.req   = (pend != 0);
        e.err   = err_m;
        t_mdl   = t_mdl + 1;
        return e;
    endfunction

    // Drive the grant for the coming edge, predict that edge, hand it over
    task automatic step(input bit en);
        exp_t e;
        AREF_EN = en;
        e = model_step(en);
        @(posedge Sys_clk);
        #1;
        sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge Sys_clk);
        #1;
        Rst_n   = 1'b0;
        AREF_EN = 1'b0;
        sb_q.push_back(reset_exp());
        @(posedge Sys_clk);
        @(negedge Sys_clk);
        @(posedge Sys_clk);
        #1;
        Rst_n = 1'b1;
        t_mdl = 0; pend = 0; err_m = 1'b0; gs = -1;
    endtask

    always @(negedge Sys_clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            vectors = vectors + 1;
            if ({COMMAND, A_ADDR, BANK_ADDR, AREF_REQ, AREF_DONE, BUSY, INIT_DONE, REF_ERR} !==
                {mon_e.cmd, mon_e.addr, mon_e.bank, mon_e.req, mon_e.done, mon_e.busy, mon_e.idone, mon_e.err}) begin
                miscompares = miscompares + 1;
                $display("FAIL outputs edge=%0d got cmd=%b a=%h ba=%h req=%b done=%b busy=%b idone=%b err=%b required cmd=%b a=%h ba=%h req=%b done=%b busy=%b idone=%b err=%b",
                         mon_e.t, COMMAND, A_ADDR, BANK_ADDR, AREF_REQ, AREF_DONE, BUSY, INIT_DONE, REF_ERR,
                         mon_e.cmd, mon_e.addr, mon_e.bank, mon_e.req, mon_e.done, mon_e.busy, mon_e.idone, mon_e.err);
            end
        end
    end

    initial begin
        apply_reset();
        // init with the grant held high throughout: it must be ignored
        repeat (45) step(1'b1);
        // no grants: requests accumulate, saturate and overrun
        repeat (71) step(1'b0);
        repeat (300) step($urandom_range(0, 3) == 0);

        // reset while a runtime refresh is in its recovery wait
        apply_reset();
        repeat (50) step(1'b0);
        step(1'b1);
        repeat (5) step(1'b0);
        apply_reset();

        // grant coinciding with a terminal count, then grant held high
        repeat (68) step(1'b0);
        repeat (60) step(1'b1);
        repeat (300) step($urandom_range(0, 3) == 0);
        repeat (300) step($urandom_range(0, 15) == 0);

        @(negedge Sys_clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain got %0d unchecked predictions required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
